// File: rtl/trng_reader.sv
// trng_reader: pulls bytes from an entropy source, runs RCT/APT health tests
// and buffers accepted bytes in a small FIFO; any failure latches an alarm.
module trng_reader #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int RCT_CUTOFF = 4,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 20,
  parameter int WARMUP_N   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [WIDTH-1:0]         i_src_dat,
  input  logic                     i_src_valid,
  output logic                     o_src_read,
  output logic [WIDTH-1:0]         o_dat,
  output logic                     o_valid,
  input  logic                     i_ready,
  input  logic                     i_alarm_clr,
  output logic                     o_alarm,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int MW = $clog2(APT_CUTOFF + 1);
  localparam int WW = $clog2(APT_WINDOW + 1);
  localparam int UW = $clog2(WARMUP_N + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {WARMUP, RUN, ALARM} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] prev, ref_b;
  logic [RW-1:0]    rep_cnt, rep_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic [WW-1:0]    win_cnt, win_nxt;
  logic [UW-1:0]    warm_cnt;
  logic             new_win, fail, clr, push, pop;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  assign o_src_read = i_src_valid & (state == WARMUP | (state == RUN & o_level < FULL));
  assign o_alarm    = state == ALARM;
  assign o_valid    = o_level != '0;
  assign o_dat      = mem[rd_ptr];
  assign clr        = o_alarm & i_alarm_clr;
  assign pop        = o_valid & i_ready;
  assign push       = o_src_read & ~fail & state == RUN;

  // Zero counters mean "no history": first byte after reset/clear starts fresh
  assign new_win   = win_cnt == '0 | win_cnt == WW'(APT_WINDOW);
  assign rep_nxt   = (rep_cnt != '0 && i_src_dat == prev) ? rep_cnt + 1'b1 : RW'(1);
  assign win_nxt   = new_win ? WW'(1) : win_cnt + 1'b1;
  assign match_nxt = new_win ? MW'(1) : match_cnt + MW'(i_src_dat == ref_b);
  assign fail      = o_src_read & (rep_nxt >= RW'(RCT_CUTOFF) | match_nxt >= MW'(APT_CUTOFF));

  always_comb begin
    state_nxt = fail ? ALARM :
                clr ? WARMUP :
                (state == WARMUP & o_src_read & warm_cnt == UW'(WARMUP_N - 1)) ? RUN : state;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= WARMUP;
    else state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset | clr) begin
      rep_cnt   <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      warm_cnt  <= '0;
    end else if (o_src_read) begin
      rep_cnt   <= rep_nxt;
      match_cnt <= match_nxt;
      win_cnt   <= win_nxt;
      prev      <= i_src_dat;
      if (new_win) ref_b <= i_src_dat;
      if (state == WARMUP) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_src_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset | fail) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_level <= o_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_trng_reader.sv
// tb_trng_reader: directed scenarios plus random traffic checked against a
// history/queue based reference model of the reader.
module tb_trng_reader;
  localparam int WN = 2, RCT = 3, APW = 16, APC = 6, DEP = 4;

  logic       clk = 0, i_reset, i_src_valid, o_src_read, o_valid, i_ready, i_alarm_clr, o_alarm;
  logic [7:0] i_src_dat, o_dat;
  logic [2:0] o_level;
  int         total = 0, bad = 0;

  bit         m_alarm;
  logic [7:0] hist[$];
  logic [7:0] fifo[$];

  trng_reader #(.WIDTH(8), .DEPTH(DEP), .RCT_CUTOFF(RCT), .APT_WINDOW(APW),
                .APT_CUTOFF(APC), .WARMUP_N(WN)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_src_dat(i_src_dat), .i_src_valid(i_src_valid),
    .o_src_read(o_src_read), .o_dat(o_dat), .o_valid(o_valid), .i_ready(i_ready),
    .i_alarm_clr(i_alarm_clr), .o_alarm(o_alarm), .o_level(o_level));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_read(input bit vld);
    return vld && !m_alarm && (hist.size() < WN || fifo.size() < DEP);
  endfunction

  // Trailing run length of identical bytes in the history
  function automatic bit rct_fail();
    int n = hist.size(), r = 1;
    for (int i = n - 2; i >= 0 && hist[i] == hist[n-1]; i--) r++;
    return r >= RCT;
  endfunction

  // Matches of the window's first byte within the current window so far
  function automatic bit apt_fail();
    int n = hist.size() - 1, ws = (n / APW) * APW, c = 0;
    for (int i = ws; i <= n; i++) if (hist[i] == hist[ws]) c++;
    return c >= APC;
  endfunction

  task automatic step(input bit rst, input bit vld, input logic [7:0] d,
                      input bit rdy, input bit clr, output bit took);
    bit fail, warm, pop;
    i_reset = rst; i_src_valid = vld; i_src_dat = d; i_ready = rdy; i_alarm_clr = clr;
    #2;
    chk("alarm", o_alarm, m_alarm);
    chk("level", o_level, fifo.size());
    chk("valid", o_valid, fifo.size() != 0);
    chk("src_read", o_src_read, exp_read(vld));
    if (fifo.size() != 0) chk("dat", o_dat, fifo[0]);
    took = exp_read(vld) && !rst;
    if (rst) begin
      m_alarm = 0; hist.delete(); fifo.delete();
    end else if (m_alarm) begin
      if (clr) begin m_alarm = 0; hist.delete(); end
    end else begin
      warm = hist.size() < WN;
      pop  = fifo.size() != 0 && rdy;
      fail = 0;
      if (took) begin hist.push_back(d); fail = rct_fail() || apt_fail(); end
      if (fail) begin
        m_alarm = 1; fifo.delete();
      end else begin
        if (pop) void'(fifo.pop_front());
        if (took && !warm) fifo.push_back(d);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input bit rdy);
    bit t = 0;
    for (int k = 0; k < 20 && !t; k++) step(0, 1, d, rdy, 0, t);
    chk("send_accepted", t, 1);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit t;
    for (int k = 0; k < n; k++) step(0, 0, 8'h00, rdy, 0, t);
  endtask

  task automatic do_reset();
    bit t;
    step(1, 0, 8'h00, 0, 0, t);
    chk("rst_level", o_level, 0);
    chk("rst_alarm", o_alarm, 0);
  endtask

  initial begin
    bit t;
    logic [7:0] seq17[4] = '{8'h11, 8'h22, 8'hA5, 8'h3C};
    logic [7:0] apt1[11] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
    i_reset = 1; i_src_valid = 0; i_src_dat = 0; i_ready = 0; i_alarm_clr = 0;
    @(posedge clk); #1;
    m_alarm = 0;
    do_reset();
    foreach (seq17[i]) begin
      send(seq17[i], 1);
      if (i == 2) chk("req17_dat_a5", o_dat, 8'hA5);
    end
    chk("req17_dat_3c", o_dat, 8'h3C);
    idle(2, 1);
    for (int i = 0; i < 3; i++) send(8'h55, 1);
    chk("req18_alarm", o_alarm, 1);
    chk("req18_level", o_level, 0);
    step(0, 1, 8'h77, 1, 0, t);
    step(0, 1, 8'h77, 1, 1, t);
    chk("req21_alarm_clr", o_alarm, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    chk("req21_dat", o_dat, 8'h03);
    send(8'h04, 0); send(8'h05, 0); send(8'h06, 0);
    chk("req19_full", o_level, 4);
    step(0, 1, 8'h07, 0, 0, t);
    step(0, 1, 8'h07, 1, 0, t);
    chk("req19_pop", o_level, 3);
    send(8'h07, 0);
    idle(6, 1);
    send(8'h08, 0); send(8'h09, 0);
    step(0, 1, 8'h0A, 1, 0, t);
    chk("req22_level", o_level, 2);
    idle(4, 1);
    do_reset();
    foreach (apt1[i]) send(apt1[i], 1);
    chk("req20_alarm", o_alarm, 1);
    do_reset();
    for (int i = 0; i < 9; i++) send(apt1[i], 1);
    for (int i = 0; i < 7; i++) send(8'h10 + 8'(i), 1);
    chk("req20_no_alarm", o_alarm, 0);
    for (int i = 0; i < 11; i++) send((i % 2 == 0) ? 8'h20 : 8'h21 + 8'(i), 1);
    chk("req20_new_ref", o_alarm, 1);
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit lo = ((c / 200) % 3) == 0;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
           lo ? 8'($urandom_range(0, 3)) : 8'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, t);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trng_reader.md
TRNG_READER -- requirements
Module: trng_reader

Interface
REQ-001 Parameters SHALL be: WIDTH, 8, byte width; DEPTH, 4, output FIFO entries (power of 2, min 2); RCT_CUTOFF, 4, repetition-count alarm threshold (min 2); APT_WINDOW, 64, adaptive-proportion window in accepted bytes; APT_CUTOFF, 20, adaptive-proportion alarm threshold (min 2); WARMUP_N, 4, bytes discarded after reset or alarm clear (min 1).
REQ-002 Ports SHALL be, clock and reset first: i_clk in 1 sole clock; i_reset in 1 synchronous active-high reset; i_src_dat in WIDTH source byte; i_src_valid in 1 source byte available; o_src_read out 1 source consume strobe; o_dat out WIDTH FIFO head; o_valid out 1 head valid; i_ready in 1 downstream consume; i_alarm_clr in 1 alarm acknowledge; o_alarm out 1 health-test failure; o_level out clog2(DEPTH)+1 FIFO occupancy.
REQ-003 One clock and a synchronous, active-high reset SHALL be used; all state SHALL update on rising i_clk only.

Function
REQ-004 Source transfer SHALL occur on a rising edge where i_src_valid & o_src_read; o_src_read SHALL be combinational: i_src_valid & (state==WARMUP | (state==RUN & o_level<DEPTH)).
REQ-005 States SHALL be WARMUP, RUN, ALARM; WARMUP->RUN when the WARMUP_N-th transfer completes without alarm; any state except ALARM ->ALARM on a failing transfer; ALARM->WARMUP on i_alarm_clr; i_alarm_clr in other states SHALL be ignored.
REQ-006 Every transferred byte (WARMUP and RUN) SHALL run both health tests; the byte SHALL be pushed into the FIFO only in RUN and only if it does not fail.
REQ-007 RCT: rep_cnt SHALL be 1 on the first byte after reset or clear, +1 when byte equals previous transferred byte, else 1; fail when rep_cnt reaches RCT_CUTOFF.
REQ-008 APT: first byte of each window SHALL be the reference with match_cnt=1; each later byte equal to reference SHALL increment match_cnt; fail when match_cnt reaches APT_CUTOFF; after APT_WINDOW bytes the next byte SHALL start a new window.
REQ-009 Counters SHALL be sized to hold their cutoff/window and SHALL never wrap before the alarm or window restart.
REQ-010 On failure, o_alarm SHALL rise the cycle after the failing transfer, FIFO SHALL be flushed (o_level=0, o_valid=0) in the same cycle, and o_src_read SHALL be 0 while in ALARM.
REQ-011 On ALARM->WARMUP, o_alarm SHALL drop next cycle and rep_cnt, match_cnt, window and warm-up counters SHALL clear.
REQ-012 o_valid SHALL equal o_level!=0; pop SHALL occur on o_valid & i_ready; o_dat SHALL present the oldest entry; i_ready with o_valid=0 SHALL have no effect.
REQ-013 Simultaneous push and pop SHALL leave o_level unchanged and preserve order; push while full is impossible by REQ-004.
REQ-014 o_dat SHALL be don't-care while o_valid=0; FIFO storage need not be reset.

Reset
REQ-015 When i_reset is sampled high: state=WARMUP, o_level=0, o_valid=0, o_alarm=0, all test and warm-up counters 0; o_src_read follows REQ-004 from the next cycle.
REQ-016 Reset mid-operation SHALL discard FIFO contents and test history with no partial push.

Verification (WIDTH=8, DEPTH=4, RCT_CUTOFF=3, APT_WINDOW=16, APT_CUTOFF=6, WARMUP_N=2)
REQ-017 Reset, source offers 0x11,0x22,0xA5,0x3C, i_ready=1 -> 0x11,0x22 dropped; o_dat 0xA5 then 0x3C with o_valid; o_alarm=0.
REQ-018 After warm-up, source offers 0x55,0x55,0x55 -> o_alarm=1 cycle after third transfer, o_level=0, o_src_read=0 while i_src_valid=1.
REQ-019 After warm-up, i_ready=0, four distinct bytes -> o_level=4, o_src_read=0; one pop -> o_level=3, fifth byte accepted next transfer, order intact.
REQ-020 Window starting 0x00 with 0x00 at positions 1,3,5,7,9,11 (others distinct) -> alarm after position 11; with only five matches -> no alarm and byte 17 becomes new reference.
REQ-021 In ALARM, pulse i_alarm_clr -> o_alarm=0 next cycle, next two bytes discarded, third byte appears on o_dat.
REQ-022 o_level=2, push and pop same edge -> o_level stays 2, pushed byte emerges third.
